// File: rtl/riscv_defs.sv
// Shared RISC-V definitions used by Control and the load/store unit:
// funct3 encodings, byte-enable codes, LSU state encoding and access checks.
package riscv_defs;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  // True when the access must be rejected: misaligned halfword/word, or an
  // funct3 value that names no supported width.
  function automatic logic access_rejected(input logic [2:0] f3, input logic [1:0] off);
    logic r;
    case (f3)
      F3_LB, F3_LBU: r = 1'b0;
      F3_LH, F3_LHU: r = off[0];
      F3_LW:         r = (off != 2'b00);
      default:       r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane extraction: shifts the addressed byte lane down to bit 0 and
// applies sign or zero extension according to funct3.
module load_extend
  import riscv_defs::*;
(
  input  logic [31:0] i_di,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_data
);

  logic [31:0] w_lane;

  assign w_lane = i_di >> {i_off, 3'b000};

  // Select width and extension mode
  always_comb begin
    o_data = w_lane;
    case (i_f3)
      F3_LB:   o_data = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_LH:   o_data = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_LBU:  o_data = {24'h000000, w_lane[7:0]};
      F3_LHU:  o_data = {16'h0000, w_lane[15:0]};
      default: o_data = w_lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request from Control, drives lane-shifted
// strobes to data memory for MEM_LATENCY cycles, and returns an extended
// load result. Rejected accesses complete in one cycle with no strobes.
module load_store_unit
  import riscv_defs::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        MemWrite,
  input  logic [3:0]  BE,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] D_MEM_DI,
  output logic [11:0] D_MEM_ADDR,
  output logic        D_MEM_WEN,
  output logic [3:0]  D_MEM_BE,
  output logic [31:0] D_MEM_DOUT,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  lsu_state_t  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [11:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_dout;
  logic        r_wen;
  logic [31:0] r_rdata;
  logic        r_busy;
  logic        r_done;
  logic        r_mis;

  logic        w_reject;
  logic [31:0] w_ext;
  logic        w_unused_addr_hi;

  // Data memory is 4 KiB; the upper address bits are not decoded here.
  assign w_unused_addr_hi = ^addr[31:12];
  assign w_reject         = access_rejected(funct3, addr[1:0]);

  load_extend u_load_extend (
    .i_di   (D_MEM_DI),
    .i_off  (r_off),
    .i_f3   (r_f3),
    .o_data (w_ext)
  );

  // Control FSM with registered memory strobes and status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_off   <= 2'b00;
      r_addr  <= 12'h000;
      r_be    <= 4'b0000;
      r_dout  <= 32'h0;
      r_wen   <= 1'b1;
      r_rdata <= 32'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_we   <= MemWrite;
            r_f3   <= funct3;
            r_off  <= addr[1:0];
            r_busy <= 1'b1;
            if (w_reject) begin
              // Skip the memory phase entirely; strobes stay idle.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_mis   <= 1'b1;
            end else begin
              r_state <= ST_ACCESS;
              r_cnt   <= LAT_M1;
              r_addr  <= {addr[11:2], 2'b00};
              r_be    <= 4'(BE << addr[1:0]);
              r_dout  <= wdata << {addr[1:0], 3'b000};
              r_wen   <= ~MemWrite;
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_be    <= 4'b0000;
            r_dout  <= 32'h0;
            r_wen   <= 1'b1;
            // Memory data is valid on the final strobe cycle.
            if (!r_we) r_rdata <= w_ext;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign D_MEM_ADDR = r_addr;
  assign D_MEM_WEN  = r_wen;
  assign D_MEM_BE   = r_be;
  assign D_MEM_DOUT = r_dout;
  assign rdata      = r_rdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign misaligned = r_mis;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL take one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of CLK.
REQ-002 Parameter MEM_LATENCY, default 1, range 1..15: number of cycles memory strobes are held per access.
REQ-003 CLK  input  1  system clock.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 start  input  1  one-cycle request from Control in MEM state.
REQ-006 MemWrite  input  1  1 = store, 0 = load.
REQ-007 BE  input  4  unshifted byte enables from Control: 0001, 0011 or 1111.
REQ-008 funct3  input  3  load/store width and signedness.
REQ-009 addr  input  32  byte address from ALU result.
REQ-010 wdata  input  32  store data (rs2).
REQ-011 D_MEM_DI  input  32  read data from data memory.
REQ-012 D_MEM_ADDR  output  12  byte address with bits [1:0] forced to 0.
REQ-013 D_MEM_WEN  output  1  active-low write enable.
REQ-014 D_MEM_BE  output  4  lane-shifted byte enables.
REQ-015 D_MEM_DOUT  output  32  lane-shifted store data.
REQ-016 rdata  output  32  extended load result, held until next completed load.
REQ-017 busy  output  1  high from the cycle after accepted start until done.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 misaligned  output  1  one-cycle pulse, coincident with done, on rejected access.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, DONE; start SHALL be accepted only in IDLE and ignored otherwise.
REQ-021 On accept, MemWrite, BE, funct3, addr[11:0] and wdata SHALL be latched; later input changes SHALL NOT affect the access.
REQ-022 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00; then IDLE->DONE directly, no strobes, rdata unchanged, misaligned=1.
REQ-023 Aligned: IDLE->ACCESS; ACCESS held exactly MEM_LATENCY cycles via down-counter; then ACCESS->DONE; DONE->IDLE after one cycle.
REQ-024 Latency: start at cycle t -> done at t+1+MEM_LATENCY (aligned), t+1 (misaligned).
REQ-025 In ACCESS only: D_MEM_BE = BE << addr[1:0], D_MEM_DOUT = wdata << 8*addr[1:0], D_MEM_WEN = 0 for stores; otherwise D_MEM_WEN = 1, D_MEM_BE = 0000.
REQ-026 Loads SHALL capture D_MEM_DI on the last ACCESS cycle edge.
REQ-027 Lane data = D_MEM_DI >> 8*addr[1:0]; funct3 000 LB and 001 LH sign-extend, 100 LBU and 101 LHU zero-extend, 010 LW passes 32 bits.
REQ-028 Unsupported funct3 (011, 110, 111) SHALL complete like misaligned: no strobes, misaligned=1.
REQ-029 Stores SHALL NOT modify rdata.
REQ-030 start in DONE cycle SHALL be ignored; start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-031 While RST=1: state IDLE, counter 0, busy 0, done 0, misaligned 0, rdata 0, D_MEM_WEN 1, D_MEM_BE 0000, D_MEM_ADDR 0, D_MEM_DOUT 0.
REQ-032 RST during ACCESS SHALL abort: no write strobe in the cycle after RST is sampled, and no done pulse for the aborted access.

Structure
REQ-033 funct3 encodings, BE codes and FSM state encodings SHALL live in the shared riscv_defs package/header used by Control.
REQ-034 Lane extraction and sign/zero extension SHALL be a combinational sub-module load_extend.

Verification
REQ-035 LW addr=0x010, D_MEM_DI=0xDEADBEEF, MEM_LATENCY=1 -> done at t+2, rdata=0xDEADBEEF, D_MEM_ADDR=0x010, WEN=1 throughout.
REQ-036 LB addr=0x013, D_MEM_DI=0x80FF7F01 -> rdata=0xFFFFFF80; LBU same -> rdata=0x00000080.
REQ-037 SH addr=0x022, wdata=0x0000ABCD -> D_MEM_BE=1100, D_MEM_DOUT=0xABCD0000, WEN=0 for exactly MEM_LATENCY cycles.
REQ-038 LW addr=0x006 -> done and misaligned at t+1, no WEN/BE activity, rdata unchanged.
REQ-039 MEM_LATENCY=3 SW with start re-asserted while busy -> second start ignored, single done at t+4.
REQ-040 RST asserted in second ACCESS cycle of SW (MEM_LATENCY=3) -> WEN=1 next cycle, no done, all outputs at reset values.
